// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: S-box table, GF(2^8) xtime, FSM states
// and sizing constants.
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } ks_state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8), reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box byte lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub
);

    assign sub = SBOX[data];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry buffer
// with a registered read port. Define KEYSCHED_RD_GUARD_EN for the rd_err read guard.
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_valid,
    output logic [3:0]       gen_count,
    input  logic             rd_en,
    input  logic [3:0]       rd_round,
    output logic [KEY_W-1:0] rd_key
`ifdef KEYSCHED_RD_GUARD_EN
    ,
    output logic             rd_err
`endif
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ks_state_t        state;
    logic [3:0]       round;
    logic [7:0]       rcon;
    logic [KEY_W-1:0] prev_p0;
    logic [KEY_W-1:0] key_buf [0:NR];

    logic             load_acc;
    logic             wr_en;
    logic [3:0]       wr_idx;
    logic [KEY_W-1:0] wr_data;
    logic [31:0]      rot_w;
    logic [31:0]      sub_w;
    logic [31:0]      w0, w1, w2, w3;

    assign load_acc = key_load && key_ready;

    // Stage p0: shared SubWord/RotWord/Rcon step on the previous round key
    assign rot_w = {prev_p0[23:0], prev_p0[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .data (rot_w[8*i +: 8]),
            .sub  (sub_w[8*i +: 8])
        );
    end

    assign w0 = prev_p0[127:96] ^ sub_w ^ {rcon, 24'h0};
    assign w1 = w0 ^ prev_p0[95:64];
    assign w2 = w1 ^ prev_p0[63:32];
    assign w3 = w2 ^ prev_p0[31:0];

    assign wr_en   = load_acc || (state == ST_EXPAND);
    assign wr_idx  = load_acc ? 4'd0 : round;
    assign wr_data = load_acc ? key_in : {w0, w1, w2, w3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            round      <= 4'd0;
            rcon       <= RCON_INIT;
            gen_count  <= 4'd0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (load_acc) begin
                        state      <= ST_EXPAND;
                        round      <= 4'd1;
                        rcon       <= RCON_INIT;
                        gen_count  <= 4'd1;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    rcon      <= xtime(rcon);
                    round     <= round + 4'd1;
                    gen_count <= gen_count + 4'd1;
                    if (round == LAST_ROUND) begin
                        state      <= ST_DONE;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    key_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Stage p1: buffer write and working-register update (data, no reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_buf[wr_idx] <= wr_data;
            prev_p0         <= wr_data;
        end
    end

`ifdef KEYSCHED_RD_GUARD_EN
    logic rd_bad;
    assign rd_bad = (rd_round > LAST_ROUND) || (rd_round >= gen_count);
`endif

    // Stage p1: registered read port; a same-cycle write is not visible until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_key <= '0;
`ifdef KEYSCHED_RD_GUARD_EN
            rd_err <= 1'b0;
`endif
        end else begin
`ifdef KEYSCHED_RD_GUARD_EN
            rd_err <= rd_en && rd_bad;
            if (rd_en) begin
                rd_key <= rd_bad ? '0 : key_buf[rd_round];
            end
`else
            if (rd_en) begin
                rd_key <= (rd_round > LAST_ROUND) ? '0 : key_buf[rd_round];
            end
`endif
        end
    end

endmodule
